edusoc_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the EduSoC REQ/VALID memory bus. Shares one memory port, such as the edusoc_basic DATA_* port, between two requesters, e.g. CPU data and a DMA/debug master, or instruction fetch and data on a unified memory. Grants use round-robin and are tracked with a small FSM. A watchdog completes hung transactions with an error response.

---
 rtl/edusoc_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_edusoc_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edusoc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : edusoc_bus_arbiter
// Description : Two-master, one-slave round-robin arbiter for the EduSoC
//               REQ/VALID memory bus, with a watchdog that completes hung
//               transactions with an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module edusoc_bus_arbiter #(
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 CPU_CLK,
    input  logic                 CPU_RES,
    // master 0
    input  logic                 M0_REQ,
    output logic                 M0_VALID,
    input  logic                 M0_WE,
    input  logic [3:0]           M0_BE,
    input  logic [31:0]          M0_ADDR,
    input  logic [31:0]          M0_WDATA,
    output logic [31:0]          M0_RDATA,
    // master 1
    input  logic                 M1_REQ,
    output logic                 M1_VALID,
    input  logic                 M1_WE,
    input  logic [3:0]           M1_BE,
    input  logic [31:0]          M1_ADDR,
    input  logic [31:0]          M1_WDATA,
    output logic [31:0]          M1_RDATA,
    // shared slave
    output logic                 S_REQ,
    input  logic                 S_VALID,
    output logic                 S_WE,
    output logic [3:0]           S_BE,
    output logic [31:0]          S_ADDR,
    output logic [31:0]          S_WDATA,
    input  logic [31:0]          S_RDATA,
    // status
    output logic [1:0]           GRANT,
    output logic                 BUS_ERR,
    output logic [ERR_CNT_W-1:0] ERR_COUNT
);

    localparam int unsigned       c_WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit                c_WD_EN   = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_last;
    logic [c_WD_W-1:0]    r_wd_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_complete;
    logic                 w_timeout;
    logic [31:0]          w_rdata;

    always_ff @(posedge CPU_CLK or posedge CPU_RES) begin
        if (CPU_RES) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_wd_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_complete) begin
                r_last   <= (r_state == ST_GRANT1);
                r_wd_cnt <= '0;
            end else if (c_WD_EN && (r_state != ST_IDLE)) begin
                r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
            end
            if (w_timeout && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        S_REQ        = 1'b0;
        S_WE         = 1'b0;
        S_BE         = '0;
        S_ADDR       = '0;
        S_WDATA      = '0;
        GRANT        = 2'b00;
        M0_VALID     = 1'b0;
        M1_VALID     = 1'b0;
        M0_RDATA     = '0;
        M1_RDATA     = '0;
        // A slave response in the timeout cycle wins over the error.
        w_rdata      = S_VALID ? S_RDATA : ERR_DATA;

        case (r_state)
            ST_IDLE: begin
                // r_last=1 means M1 was served last, so M0 wins a tie.
                if (M0_REQ && (!M1_REQ || r_last)) begin
                    w_next_state = ST_GRANT0;
                end else if (M1_REQ) begin
                    w_next_state = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                S_REQ      = 1'b1;
                S_WE       = M0_WE;
                S_BE       = M0_BE;
                S_ADDR     = M0_ADDR;
                S_WDATA    = M0_WDATA;
                GRANT      = 2'b01;
                w_timeout  = c_WD_EN && !S_VALID && (r_wd_cnt == c_WD_LAST);
                w_complete = S_VALID || w_timeout;
                if (w_complete) begin
                    M0_VALID     = 1'b1;
                    M0_RDATA     = w_rdata;
                    w_next_state = M1_REQ ? ST_GRANT1 : ST_IDLE;
                end
            end
            ST_GRANT1: begin
                S_REQ      = 1'b1;
                S_WE       = M1_WE;
                S_BE       = M1_BE;
                S_ADDR     = M1_ADDR;
                S_WDATA    = M1_WDATA;
                GRANT      = 2'b10;
                w_timeout  = c_WD_EN && !S_VALID && (r_wd_cnt == c_WD_LAST);
                w_complete = S_VALID || w_timeout;
                if (w_complete) begin
                    M1_VALID     = 1'b1;
                    M1_RDATA     = w_rdata;
                    w_next_state = M0_REQ ? ST_GRANT0 : ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign BUS_ERR   = w_timeout;
    assign ERR_COUNT = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_edusoc_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_edusoc_bus_arbiter
// Description : Randomized scoreboard bench for edusoc_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edusoc_bus_arbiter;

    localparam int          TIMEOUT   = 4;
    localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;
    localparam int          ERR_CNT_W = 2;

    logic                 CPU_CLK = 1'b0;
    logic                 CPU_RES;
    logic                 M0_REQ, M0_WE, M1_REQ, M1_WE;
    logic [3:0]           M0_BE, M1_BE;
    logic [31:0]          M0_ADDR, M0_WDATA, M1_ADDR, M1_WDATA;
    logic                 M0_VALID, M1_VALID;
    logic [31:0]          M0_RDATA, M1_RDATA;
    logic                 S_REQ, S_VALID, S_WE;
    logic [3:0]           S_BE;
    logic [31:0]          S_ADDR, S_WDATA, S_RDATA;
    logic [1:0]           GRANT;
    logic                 BUS_ERR;
    logic [ERR_CNT_W-1:0] ERR_COUNT;

    edusoc_bus_arbiter #(
        .TIMEOUT   (TIMEOUT),
        .ERR_DATA  (ERR_DATA),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .CPU_CLK   (CPU_CLK),
        .CPU_RES   (CPU_RES),
        .M0_REQ    (M0_REQ),
        .M0_VALID  (M0_VALID),
        .M0_WE     (M0_WE),
        .M0_BE     (M0_BE),
        .M0_ADDR   (M0_ADDR),
        .M0_WDATA  (M0_WDATA),
        .M0_RDATA  (M0_RDATA),
        .M1_REQ    (M1_REQ),
        .M1_VALID  (M1_VALID),
        .M1_WE     (M1_WE),
        .M1_BE     (M1_BE),
        .M1_ADDR   (M1_ADDR),
        .M1_WDATA  (M1_WDATA),
        .M1_RDATA  (M1_RDATA),
        .S_REQ     (S_REQ),
        .S_VALID   (S_VALID),
        .S_WE      (S_WE),
        .S_BE      (S_BE),
        .S_ADDR    (S_ADDR),
        .S_WDATA   (S_WDATA),
        .S_RDATA   (S_RDATA),
        .GRANT     (GRANT),
        .BUS_ERR   (BUS_ERR),
        .ERR_COUNT (ERR_COUNT)
    );

    always #10 CPU_CLK = ~CPU_CLK;

    typedef struct {
        logic [1:0]  grant;
        logic        sreq;
        logic        swe;
        logic [3:0]  sbe;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic        v0;
        logic        v1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        berr;
        logic [31:0] ecnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // master-side transaction state and stimulus knobs
    bit          m_act[2];
    int          m_gap[2];
    logic        m_we[2];
    logic [3:0]  m_be[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];
    int          req_pct[2];
    bit          fx_en[2];
    logic        fx_we[2];
    logic [3:0]  fx_be[2];
    logic [31:0] fx_addr[2];
    logic [31:0] fx_wdata[2];
    int          gap_max, fix_dly, hang_pct, stray_pct;
    bit          fix_rd_en;
    logic [31:0] fix_rd;

    // reference model: current owner (-1 none), grant age, last served, error tally
    int own, wt, last, ecnt, dly;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic drive_masters();
        M0_REQ = m_act[0]; M0_WE = m_we[0]; M0_BE = m_be[0];
        M0_ADDR = m_addr[0]; M0_WDATA = m_wdata[0];
        M1_REQ = m_act[1]; M1_WE = m_we[1]; M1_BE = m_be[1];
        M1_ADDR = m_addr[1]; M1_WDATA = m_wdata[1];
    endtask

    task automatic step();
        exp_t        e;
        int          done;
        logic [31:0] rdat;
        @(negedge CPU_CLK);
        for (int n = 0; n < 2; n++) begin
            if (!m_act[n]) begin
                if (m_gap[n] > 0) m_gap[n]--;
                else if ($urandom_range(99) < req_pct[n]) m_act[n] = 1'b1;
                m_we[n]    = 1'($urandom);
                m_be[n]    = 4'($urandom);
                m_addr[n]  = $urandom;
                m_wdata[n] = $urandom;
                if (m_act[n] && fx_en[n]) begin
                    m_we[n] = fx_we[n]; m_be[n] = fx_be[n];
                    m_addr[n] = fx_addr[n]; m_wdata[n] = fx_wdata[n];
                end
            end
        end
        drive_masters();

        // slave: fixed response delay per grant, measured in grant cycles
        if (own >= 0 && wt == 0) begin
            if (fix_dly >= 0) dly = fix_dly;
            else if ($urandom_range(99) < hang_pct) dly = 1000;
            else dly = $urandom_range(0, 4);
        end
        S_VALID = (own >= 0) ? (wt == dly) : ($urandom_range(99) < stray_pct);
        S_RDATA = fix_rd_en ? fix_rd : $urandom;

        e.grant = 2'b00; e.sreq = 1'b0; e.swe = 1'b0; e.sbe = '0;
        e.saddr = '0; e.swdata = '0; e.v0 = 1'b0; e.v1 = 1'b0;
        e.rd0 = '0; e.rd1 = '0; e.berr = 1'b0; e.ecnt = ecnt;
        done = -1;
        rdat = '0;
        if (own >= 0) begin
            e.grant  = (own == 0) ? 2'b01 : 2'b10;
            e.sreq   = 1'b1;
            e.swe    = m_we[own];
            e.sbe    = m_be[own];
            e.saddr  = m_addr[own];
            e.swdata = m_wdata[own];
            if (S_VALID) begin
                done = own; rdat = S_RDATA;
            end else if (wt == TIMEOUT - 1) begin
                done = own; rdat = ERR_DATA; e.berr = 1'b1;
            end
        end
        if (done == 0) begin e.v0 = 1'b1; e.rd0 = rdat; end
        if (done == 1) begin e.v1 = 1'b1; e.rd1 = rdat; end
        exp_q.push_back(e);

        if (done >= 0) begin
            last = done;
            wt   = 0;
            if (e.berr && ecnt < (1 << ERR_CNT_W) - 1) ecnt++;
            m_act[done] = 1'b0;
            m_gap[done] = $urandom_range(0, gap_max);
            own = m_act[1 - done] ? 1 - done : -1;
        end else if (own >= 0) begin
            wt++;
        end else if (m_act[0] && m_act[1]) begin
            own = 1 - last;
        end else if (m_act[0]) begin
            own = 0;
        end else if (m_act[1]) begin
            own = 1;
        end
    endtask

    task automatic do_reset();
        CPU_RES = 1'b1;
        exp_q.delete();
        own = -1; wt = 0; last = 1; ecnt = 0; dly = 0;
        for (int n = 0; n < 2; n++) begin
            m_act[n] = 1'b0; m_gap[n] = 0; m_we[n] = 1'b0; m_be[n] = '0;
            m_addr[n] = '0; m_wdata[n] = '0;
        end
        drive_masters();
        S_VALID = 1'b0;
        S_RDATA = '0;
        repeat (2) @(negedge CPU_CLK);
        #3;
        chk("rst_grant", 32'(GRANT), 32'd0);
        chk("rst_sreq", 32'(S_REQ), 32'd0);
        chk("rst_valid", {30'd0, M1_VALID, M0_VALID}, 32'd0);
        chk("rst_err", {29'd0, BUS_ERR, 2'(ERR_COUNT)}, 32'd0);
        chk("rst_saddr", S_ADDR | S_WDATA | 32'(S_BE) | 32'(S_WE), 32'd0);
        @(negedge CPU_CLK);
        CPU_RES = 1'b0;
    endtask

    task automatic set_knobs(input int p0, input int p1, input int gmax,
                             input int fdly, input int hpct, input int spct);
        req_pct[0] = p0; req_pct[1] = p1; gap_max = gmax;
        fix_dly = fdly; hang_pct = hpct; stray_pct = spct;
        fx_en[0] = 1'b0; fx_en[1] = 1'b0; fix_rd_en = 1'b0;
    endtask

    // monitor: compares the DUT against the record queued for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CPU_CLK);
            #3;
            if (!CPU_RES && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant", 32'(GRANT), 32'(e.grant));
                chk("s_req", 32'(S_REQ), 32'(e.sreq));
                chk("s_we", 32'(S_WE), 32'(e.swe));
                chk("s_be", 32'(S_BE), 32'(e.sbe));
                chk("s_addr", S_ADDR, e.saddr);
                chk("s_wdata", S_WDATA, e.swdata);
                chk("m0_valid", 32'(M0_VALID), 32'(e.v0));
                chk("m1_valid", 32'(M1_VALID), 32'(e.v1));
                chk("m0_rdata", M0_RDATA, e.rd0);
                chk("m1_rdata", M1_RDATA, e.rd1);
                chk("bus_err", 32'(BUS_ERR), 32'(e.berr));
                chk("err_count", 32'(ERR_COUNT), e.ecnt);
            end
        end
    end

    initial begin
        bit hit;
        CPU_RES = 1'b1;
        set_knobs(0, 0, 0, -1, 0, 0);
        do_reset();

        // single M0 read of 0x100, slave answers in the third grant cycle
        set_knobs(100, 0, 1000, 2, 0, 0);
        fx_en[0] = 1'b1; fx_we[0] = 1'b0; fx_be[0] = 4'hF;
        fx_addr[0] = 32'h100; fx_wdata[0] = 32'h0;
        fix_rd_en = 1'b1; fix_rd = 32'hCAFE0001;
        repeat (8) step();

        // both masters requesting continuously from reset: strict alternation
        do_reset();
        set_knobs(100, 100, 0, -1, 0, 0);
        repeat (40) step();

        // M1 write forwarding
        do_reset();
        set_knobs(0, 100, 2, -1, 0, 0);
        fx_en[1] = 1'b1; fx_we[1] = 1'b1; fx_be[1] = 4'b0011;
        fx_addr[1] = 32'h2004; fx_wdata[1] = 32'h1234;
        repeat (12) step();

        // hung slave: repeated timeouts saturate the counter; stray VALIDs in IDLE
        do_reset();
        set_knobs(100, 0, 2, -1, 100, 40);
        repeat (48) step();

        // random mix
        do_reset();
        set_knobs(50, 50, 3, -1, 10, 20);
        repeat (1500) step();

        // async reset while M1 sits in its timeout cycle
        do_reset();
        set_knobs(0, 100, 0, -1, 100, 0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (own == 1 && wt == TIMEOUT - 1) hit = 1'b1;
        end
        if (!hit) begin
            miscompares++;
            $display("FAIL grant1_wait: got no GRANT1 timeout cycle expected one within 20 cycles");
        end else begin
            step();
            #5;
            chk("pre_rst_grant", 32'(GRANT), 32'd2);
            chk("pre_rst_m1_valid", 32'(M1_VALID), 32'd1);
            CPU_RES = 1'b1;
            #1;
            chk("async_sreq", 32'(S_REQ), 32'd0);
            chk("async_grant", 32'(GRANT), 32'd0);
            chk("async_m1_valid", 32'(M1_VALID), 32'd0);
            chk("async_m1_rdata", M1_RDATA, 32'd0);
        end
        do_reset();
        set_knobs(100, 100, 0, -1, 0, 0);
        repeat (20) step();

        @(negedge CPU_CLK);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
